// File: rtl/decode_issue_buffer.sv
// rtl/decode_issue_buffer.sv - decode slot buffer between the instruction queue and the issue scoreboard
//
// Holds up to LANES decoded instructions as a contiguous oldest-first prefix.
// A new group is taken only when the buffer is empty or drains completely in
// the same cycle. Otherwise the oldest issued slots are removed and the rest
// shift down.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush_i             clears every slot next cycle; inputs ignored that cycle
//   in_valid_i          per-lane valid, bit 0 oldest (only the leading run of 1s is taken)
//   in_pc_i, in_inst_i  per-lane PC / instruction, lane k at [k*W +: W]
//   in_ready_o          a new group may be accepted this cycle
//   issue_cnt_i         number of oldest held slots issued this cycle (clamped)
//   out_valid_o/pc/inst held slots, slot 0 oldest
//   out_rs1/rs2/rs3/rd  register fields of each held slot
//   out_endsim_o        slot holds the end-of-simulation instruction
//   occupancy_o         number of valid slots
module decode_issue_buffer #(
    parameter int LANES = 2,
    parameter int PC_W  = 64,
    localparam int CNT_W = $clog2(LANES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic [LANES-1:0]      in_valid_i,
    input  logic [LANES*PC_W-1:0] in_pc_i,
    input  logic [LANES*32-1:0]   in_inst_i,
    output logic                  in_ready_o,
    input  logic [CNT_W-1:0]      issue_cnt_i,
    output logic [LANES-1:0]      out_valid_o,
    output logic [LANES*PC_W-1:0] out_pc_o,
    output logic [LANES*32-1:0]   out_inst_o,
    output logic [LANES*5-1:0]    out_rs1_o,
    output logic [LANES*5-1:0]    out_rs2_o,
    output logic [LANES*5-1:0]    out_rs3_o,
    output logic [LANES*5-1:0]    out_rd_o,
    output logic [LANES-1:0]      out_endsim_o,
    output logic [CNT_W-1:0]      occupancy_o
);

    localparam logic [31:0] ENDSIM_INST = 32'h0000_006b;

    logic [LANES-1:0]      valid_q, valid_d;
    logic [LANES*PC_W-1:0] pc_q, pc_d;
    logic [LANES*32-1:0]   inst_q, inst_d;

    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] eff;
    logic [LANES-1:0] prefix;
    logic             run;
    logic             accept;

    // Valid slots are always a prefix, but a popcount keeps occupancy exact
    // without relying on that invariant.
    always_comb begin
        occ = '0;
        for (int k = 0; k < LANES; k++) begin
            occ = occ + CNT_W'(valid_q[k]);
        end
    end

    assign eff        = (issue_cnt_i < occ) ? issue_cnt_i : occ;
    assign in_ready_o = !flush_i && (eff == occ);
    assign accept     = in_ready_o && in_valid_i[0];

    // Leading run of valid lanes; a hole ends the group.
    always_comb begin
        run    = 1'b1;
        prefix = '0;
        for (int k = 0; k < LANES; k++) begin
            run       = run & in_valid_i[k];
            prefix[k] = run;
        end
    end

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (flush_i) begin
            valid_d = '0;
            pc_d    = '0;
            inst_d  = '0;
        end else if (accept) begin
            for (int k = 0; k < LANES; k++) begin
                valid_d[k]              = prefix[k];
                pc_d[k*PC_W +: PC_W]    = prefix[k] ? in_pc_i[k*PC_W +: PC_W] : '0;
                inst_d[k*32 +: 32]      = prefix[k] ? in_inst_i[k*32 +: 32] : '0;
            end
        end else begin
            // Shift down by the issued count; eff == 0 degenerates to a hold.
            for (int k = 0; k < LANES; k++) begin
                if (k + int'(eff) < LANES) begin
                    valid_d[k]           = valid_q[k + int'(eff)];
                    pc_d[k*PC_W +: PC_W] = pc_q[(k + int'(eff))*PC_W +: PC_W];
                    inst_d[k*32 +: 32]   = inst_q[(k + int'(eff))*32 +: 32];
                end else begin
                    valid_d[k]           = 1'b0;
                    pc_d[k*PC_W +: PC_W] = '0;
                    inst_d[k*32 +: 32]   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    always_comb begin
        out_rs1_o    = '0;
        out_rs2_o    = '0;
        out_rs3_o    = '0;
        out_rd_o     = '0;
        out_endsim_o = '0;
        for (int k = 0; k < LANES; k++) begin
            out_rs1_o[k*5 +: 5] = inst_q[k*32 + 15 +: 5];
            out_rs2_o[k*5 +: 5] = inst_q[k*32 + 20 +: 5];
            out_rs3_o[k*5 +: 5] = inst_q[k*32 + 27 +: 5];
            out_rd_o[k*5 +: 5]  = inst_q[k*32 + 7 +: 5];
            out_endsim_o[k]     = valid_q[k] && (inst_q[k*32 +: 32] == ENDSIM_INST);
        end
    end

    assign out_valid_o = valid_q;
    assign out_pc_o    = pc_q;
    assign out_inst_o  = inst_q;
    assign occupancy_o = occ;

endmodule

// File: tb/tb_decode_issue_buffer.sv
// tb/tb_decode_issue_buffer.sv - directed vector bench for decode_issue_buffer
module tb_decode_issue_buffer;

    logic clk;
    logic rst_n;

    // 2-lane instance
    logic         flush;
    logic [1:0]   in_valid;
    logic [127:0] in_pc;
    logic [63:0]  in_inst;
    logic         in_ready;
    logic [1:0]   issue_cnt;
    logic [1:0]   out_valid;
    logic [127:0] out_pc;
    logic [63:0]  out_inst;
    logic [9:0]   out_rs1, out_rs2, out_rs3, out_rd;
    logic [1:0]   out_endsim;
    logic [1:0]   occupancy;

    // 4-lane instance
    logic         flush4;
    logic [3:0]   in_valid4;
    logic [255:0] in_pc4;
    logic [127:0] in_inst4;
    logic         in_ready4;
    logic [2:0]   issue_cnt4;
    logic [3:0]   out_valid4;
    logic [255:0] out_pc4;
    logic [127:0] out_inst4;
    logic [19:0]  out_rs1_4, out_rs2_4, out_rs3_4, out_rd_4;
    logic [3:0]   out_endsim4;
    logic [2:0]   occupancy4;

    decode_issue_buffer #(.LANES(2), .PC_W(64)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_pc_i(in_pc), .in_inst_i(in_inst),
        .in_ready_o(in_ready), .issue_cnt_i(issue_cnt),
        .out_valid_o(out_valid), .out_pc_o(out_pc), .out_inst_o(out_inst),
        .out_rs1_o(out_rs1), .out_rs2_o(out_rs2), .out_rs3_o(out_rs3), .out_rd_o(out_rd),
        .out_endsim_o(out_endsim), .occupancy_o(occupancy)
    );

    decode_issue_buffer #(.LANES(4), .PC_W(64)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush4),
        .in_valid_i(in_valid4), .in_pc_i(in_pc4), .in_inst_i(in_inst4),
        .in_ready_o(in_ready4), .issue_cnt_i(issue_cnt4),
        .out_valid_o(out_valid4), .out_pc_o(out_pc4), .out_inst_o(out_inst4),
        .out_rs1_o(out_rs1_4), .out_rs2_o(out_rs2_4), .out_rs3_o(out_rs3_4), .out_rd_o(out_rd_4),
        .out_endsim_o(out_endsim4), .occupancy_o(occupancy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        flush;
        logic [1:0]  vld;
        logic [63:0] pc0, pc1;
        logic [31:0] i0, i1;
        logic [1:0]  cnt;
        logic        e_ready;
        logic [1:0]  e_valid;
        logic [63:0] e_pc0, e_pc1;
        logic [31:0] e_i0, e_i1;
        logic [1:0]  e_occ;
        logic [1:0]  e_endsim;
    } vec_t;

    vec_t vecs[11];

    logic [31:0] ia, ib, ic, ie;

    initial begin
        ia = {5'd3, 2'd0, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33};
        ib = {5'd7, 2'd0, 5'd6, 5'd5, 3'd0, 5'd8, 7'h13};
        ic = 32'h0010_0093;
        ie = 32'h0000_006b;

        //            fl vld   pc0      pc1      i0  i1  cnt rdy  e_vld e_pc0    e_pc1    e_i0 e_i1 occ endsim
        vecs[0]  = '{1'b0, 2'b11, 64'h1000, 64'h1004, ia, ib, 2'd0, 1'b1, 2'b11, 64'h1000, 64'h1004, ia, ib, 2'd2, 2'b00};
        vecs[1]  = '{1'b0, 2'b00, 64'h0,    64'h0,    0,  0,  2'd0, 1'b0, 2'b11, 64'h1000, 64'h1004, ia, ib, 2'd2, 2'b00};
        vecs[2]  = '{1'b0, 2'b11, 64'h2000, 64'h2004, ic, ic, 2'd1, 1'b0, 2'b01, 64'h1004, 64'h0,    ib, 0,  2'd1, 2'b00};
        vecs[3]  = '{1'b0, 2'b10, 64'h3000, 64'h3004, ic, ic, 2'd1, 1'b1, 2'b00, 64'h0,    64'h0,    0,  0,  2'd0, 2'b00};
        vecs[4]  = '{1'b0, 2'b01, 64'h4000, 64'h4004, ic, ie, 2'd3, 1'b1, 2'b01, 64'h4000, 64'h0,    ic, 0,  2'd1, 2'b00};
        vecs[5]  = '{1'b0, 2'b11, 64'h5000, 64'h5004, ia, ib, 2'd3, 1'b1, 2'b11, 64'h5000, 64'h5004, ia, ib, 2'd2, 2'b00};
        vecs[6]  = '{1'b1, 2'b11, 64'h6000, 64'h6004, ie, ie, 2'd2, 1'b0, 2'b00, 64'h0,    64'h0,    0,  0,  2'd0, 2'b00};
        vecs[7]  = '{1'b0, 2'b11, 64'h7000, 64'h7004, ic, ie, 2'd0, 1'b1, 2'b11, 64'h7000, 64'h7004, ic, ie, 2'd2, 2'b10};
        vecs[8]  = '{1'b0, 2'b00, 64'h0,    64'h0,    0,  0,  2'd2, 1'b1, 2'b00, 64'h0,    64'h0,    0,  0,  2'd0, 2'b00};
        vecs[9]  = '{1'b0, 2'b11, 64'h9000, 64'h9004, ie, ic, 2'd2, 1'b1, 2'b11, 64'h9000, 64'h9004, ie, ic, 2'd2, 2'b01};
        vecs[10] = '{1'b0, 2'b00, 64'h0,    64'h0,    0,  0,  2'd1, 1'b0, 2'b01, 64'h9004, 64'h0,    ic, 0,  2'd1, 2'b00};

        rst_n = 1'b0; flush = 1'b0; in_valid = '0; in_pc = '0; in_inst = '0; issue_cnt = '0;
        flush4 = 1'b0; in_valid4 = '0; in_pc4 = '0; in_inst4 = '0; issue_cnt4 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", out_valid, 2'b00);
        chk("reset_occ", occupancy, 2'd0);
        chk("reset_ready", in_ready, 1'b1);
        chk("reset_valid4", out_valid4, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            flush     = vecs[i].flush;
            in_valid  = vecs[i].vld;
            in_pc     = {vecs[i].pc1, vecs[i].pc0};
            in_inst   = {vecs[i].i1, vecs[i].i0};
            issue_cnt = vecs[i].cnt;
            #1;
            chk($sformatf("v%0d_ready", i), in_ready, vecs[i].e_ready);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), out_valid, vecs[i].e_valid);
            chk($sformatf("v%0d_pc", i), out_pc, {vecs[i].e_pc1, vecs[i].e_pc0});
            chk($sformatf("v%0d_inst", i), out_inst, {vecs[i].e_i1, vecs[i].e_i0});
            chk($sformatf("v%0d_occ", i), occupancy, vecs[i].e_occ);
            chk($sformatf("v%0d_endsim", i), out_endsim, vecs[i].e_endsim);
            if (i == 0) begin
                chk("fields_rs1", out_rs1, {5'd5, 5'd1});
                chk("fields_rs2", out_rs2, {5'd6, 5'd2});
                chk("fields_rs3", out_rs3, {5'd7, 5'd3});
                chk("fields_rd",  out_rd,  {5'd8, 5'd4});
            end
            @(negedge clk);
        end

        // Fill (one slot held, it drains this cycle), stall, then reset mid-stall.
        flush = 1'b0; in_valid = 2'b11; in_pc = {64'ha004, 64'ha000}; in_inst = {ie, ic}; issue_cnt = 2'd1;
        #1;
        chk("refill_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        chk("refill_valid", out_valid, 2'b11);
        @(negedge clk);
        in_valid = 2'b00; issue_cnt = 2'd0;
        @(posedge clk); #1;
        chk("stall_pc", out_pc, {64'ha004, 64'ha000});
        chk("stall_endsim", out_endsim, 2'b10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 2'b00);
        chk("rst_pc", out_pc, 128'h0);
        chk("rst_inst", out_inst, 64'h0);
        chk("rst_occ", occupancy, 2'd0);
        chk("rst_endsim", out_endsim, 2'b00);
        chk("rst_ready", in_ready, 1'b1);
        flush = 1'b1;
        #1;
        chk("rst_flush_ready", in_ready, 1'b0);
        flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 2'b11; in_pc = {64'hb004, 64'hb000}; in_inst = {ic, ic};
        @(posedge clk); #1;
        chk("post_rst_valid", out_valid, 2'b11);
        chk("post_rst_pc", out_pc, {64'hb004, 64'hb000});
        @(negedge clk);
        in_valid = 2'b00;

        // 4-lane: fill, partial drain, refill, full drain with new 3-lane group.
        in_valid4 = 4'b1111; in_pc4 = {64'h10c, 64'h108, 64'h104, 64'h100}; issue_cnt4 = 3'd0;
        #1;
        chk("l4_fill_ready", in_ready4, 1'b1);
        @(posedge clk); #1;
        chk("l4_fill_valid", out_valid4, 4'b1111);
        chk("l4_fill_occ", occupancy4, 3'd4);
        @(negedge clk);
        in_pc4 = {64'h20c, 64'h208, 64'h204, 64'h200}; issue_cnt4 = 3'd3;
        #1;
        chk("l4_part_ready", in_ready4, 1'b0);
        @(posedge clk); #1;
        chk("l4_part_valid", out_valid4, 4'b0001);
        chk("l4_part_pc", out_pc4, {192'h0, 64'h10c});
        chk("l4_part_occ", occupancy4, 3'd1);
        @(negedge clk);
        in_pc4 = {64'h30c, 64'h308, 64'h304, 64'h300}; issue_cnt4 = 3'd1;
        #1;
        chk("l4_refill_ready", in_ready4, 1'b1);
        @(posedge clk); #1;
        chk("l4_refill_pc", out_pc4, {64'h30c, 64'h308, 64'h304, 64'h300});
        @(negedge clk);
        in_valid4 = 4'b0111; in_pc4 = {64'h40c, 64'h408, 64'h404, 64'h400}; issue_cnt4 = 3'd4;
        #1;
        chk("l4_swap_ready", in_ready4, 1'b1);
        @(posedge clk); #1;
        chk("l4_swap_valid", out_valid4, 4'b0111);
        chk("l4_swap_pc", out_pc4, {64'h0, 64'h408, 64'h404, 64'h400});
        chk("l4_swap_occ", occupancy4, 3'd3);
        @(negedge clk);
        in_valid4 = '0; issue_cnt4 = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
